// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, funct3 values,
// ALU/immediate select codes and the 4-bit FSM state type.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC_R = 4'd7,
        S_EXEC_I = 4'd8,
        S_ALUWB  = 4'd9,
        S_BRANCH = 4'd10,
        S_JAL    = 4'd11,
        S_JALR   = 4'd12,
        S_LUI    = 4'd13,
        S_AUIPC  = 4'd14,
        S_TRAP   = 4'd15
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Maps funct3/funct7b5 of an OP or OP-IMM instruction to an ALU operation and
// flags encodings that cannot be expressed with the visible instruction bits.
module alu_op_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_ctrl,
    output logic       illegal
);

    logic is_r;
    assign is_r = (opcode == OP_R);

    always_comb begin
        alu_ctrl = ALU_ADD;
        illegal  = 1'b0;
        case (funct3)
            F3_ADD:  alu_ctrl = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
            F3_SLL:  alu_ctrl = ALU_SLL;
            F3_SLT:  alu_ctrl = ALU_SLT;
            F3_SLTU: alu_ctrl = ALU_SLTU;
            F3_XOR:  alu_ctrl = ALU_XOR;
            F3_SR:   alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_ctrl = ALU_OR;
            default: alu_ctrl = ALU_AND;
        endcase
        // For OP-IMM, bit 30 is an immediate bit except on the shift encodings.
        if (is_r && funct7b5 && (funct3 != F3_ADD) && (funct3 != F3_SR))
            illegal = 1'b1;
        if (!is_r && (funct3 == F3_SLL) && funct7b5)
            illegal = 1'b1;
        if ((opcode != OP_R) && (opcode != OP_I))
            illegal = 1'b1;
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// resolves branches from ALU flags and traps on bad opcodes or memory timeouts.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] instr,
    input  logic            flag_n,
    input  logic            flag_z,
    input  logic            flag_c,
    input  logic            flag_v,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic            adr_src,
    output logic            ir_write,
    output logic            pc_write,
    output logic            pc_src,
    output logic            reg_write,
    output logic [1:0]      alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [3:0]      alu_ctrl,
    output logic [2:0]      imm_src,
    output logic [1:0]      result_src,
    output logic [2:0]      load_ctrl,
    output logic [1:0]      store_ctrl,
    output logic            illegal_inst,
    output logic            bus_error,
    output logic [3:0]      state_o
);

    if (XLEN != 32) begin : g_xlen_check
        $fatal(1, "rv_multicycle_ctrl supports XLEN=32 only");
    end
    if ((2 ** CNT_W) <= MEM_TIMEOUT) begin : g_cnt_check
        $fatal(1, "CNT_W too narrow for MEM_TIMEOUT");
    end

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             illegal_reg, illegal_next;
    logic             bus_error_reg, bus_error_next;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [3:0] dec_alu_ctrl;
    logic       dec_illegal;
    logic       in_mem, timeout, br_taken, br_legal;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7b5     = instr[30];
    assign unused_instr = ^{instr[XLEN-1:31], instr[29:15], instr[11:7]};

    alu_op_decode u_alu_dec (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .alu_ctrl (dec_alu_ctrl),
        .illegal  (dec_illegal)
    );

    assign in_mem  = (state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);
    assign mem_req = in_mem;
    // A ready on the last allowed wait cycle still counts as a handshake.
    assign timeout = (MEM_TIMEOUT != 0) && in_mem && !mem_ready
                     && (wait_cnt_reg == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            F3_BEQ:  br_taken = flag_z;
            F3_BNE:  br_taken = !flag_z;
            F3_BLT:  br_taken = flag_n ^ flag_v;
            F3_BGE:  br_taken = !(flag_n ^ flag_v);
            F3_BLTU: br_taken = !flag_c;
            F3_BGEU: br_taken = flag_c;
            default: br_taken = 1'b0;
        endcase
    end
    assign br_legal = (funct3 != 3'b010) && (funct3 != 3'b011);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            wait_cnt_reg  <= '0;
            illegal_reg   <= 1'b0;
            bus_error_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            illegal_reg   <= illegal_next;
            bus_error_reg <= bus_error_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        illegal_next   = illegal_reg;
        bus_error_next = bus_error_reg;
        mem_we         = 1'b0;
        adr_src        = 1'b0;
        ir_write       = 1'b0;
        pc_write       = 1'b0;
        pc_src         = 1'b0;
        reg_write      = 1'b0;
        alu_src_a      = 2'd0;
        alu_src_b      = 2'd0;
        alu_ctrl       = ALU_ADD;
        imm_src        = IMM_I;
        result_src     = 2'd0;
        load_ctrl      = 3'd0;
        store_ctrl     = 2'd0;
        case (state_reg)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                alu_src_b = 2'd2;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute the B/J target from the old PC for branches and JAL.
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXEC_R;
                    OP_I:              state_next = S_EXEC_I;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    default: begin
                        state_next   = S_TRAP;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 2'd1;
                alu_src_b  = 2'd1;
                imm_src    = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_next = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                result_src = 2'd1;
                load_ctrl  = funct3;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                mem_we     = 1'b1;
                adr_src    = 1'b1;
                store_ctrl = funct3[1:0];
                if (mem_ready) state_next = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a = 2'd1;
                alu_src_b = (state_reg == S_EXEC_I) ? 2'd1 : 2'd0;
                alu_ctrl  = dec_alu_ctrl;
                if (dec_illegal) begin
                    state_next   = S_TRAP;
                    illegal_next = 1'b1;
                end else begin
                    state_next = S_ALUWB;
                end
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'd1;
                alu_ctrl  = ALU_SUB;
                imm_src   = IMM_B;
                if (br_legal) begin
                    pc_write   = br_taken;
                    pc_src     = br_taken;
                    state_next = S_FETCH;
                end else begin
                    state_next   = S_TRAP;
                    illegal_next = 1'b1;
                end
            end
            S_JAL, S_JALR: begin
                alu_src_a  = (state_reg == S_JAL) ? 2'd2 : 2'd1;
                alu_src_b  = 2'd1;
                imm_src    = (state_reg == S_JAL) ? IMM_J : IMM_I;
                pc_write   = 1'b1;
                pc_src     = 1'b1;
                reg_write  = 1'b1;
                result_src = 2'd2;
                state_next = S_FETCH;
            end
            S_LUI, S_AUIPC: begin
                alu_src_a  = (state_reg == S_LUI) ? 2'd3 : 2'd2;
                alu_src_b  = 2'd1;
                imm_src    = IMM_U;
                state_next = S_ALUWB;
            end
            default: state_next = S_TRAP;
        endcase
        if (timeout) begin
            state_next     = S_TRAP;
            bus_error_next = 1'b1;
        end
    end

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if ((state_next != state_reg) || (in_mem && mem_ready))
            wait_cnt_next = '0;
        else if (in_mem)
            wait_cnt_next = wait_cnt_reg + CNT_W'(1);
    end

    assign illegal_inst = illegal_reg;
    assign bus_error    = bus_error_reg;
    assign state_o      = state_reg;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Randomized scoreboard bench: an instruction-level reference model queues the expected
// per-cycle control outputs; a negedge monitor pops and compares them.
module tb_rv_multicycle_ctrl;
    import rv_ctrl_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        flag_n, flag_z, flag_c, flag_v, mem_ready;
    logic        mem_req, mem_we, adr_src, ir_write, pc_write, pc_src, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src, store_ctrl;
    logic [3:0]  alu_ctrl, state_o;
    logic [2:0]  imm_src, load_ctrl;
    logic        illegal_inst, bus_error;

    always #5 clk = ~clk;

    rv_multicycle_ctrl #(.XLEN(32), .MEM_TIMEOUT(T), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .imm_src(imm_src),
        .result_src(result_src), .load_ctrl(load_ctrl), .store_ctrl(store_ctrl),
        .illegal_inst(illegal_inst), .bus_error(bus_error), .state_o(state_o)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       req, we, adr, irw, pcw, pcs, rw;
        logic [1:0] rs;
        logic [2:0] ld;
        logic [1:0] stc;
        logic       ill, berr;
        logic       dp;
        logic [1:0] sa, sb;
        logic [3:0] alu;
        logic       ci;
        logic [2:0] imm;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc_no = 0;
    bit          mon_en = 1'b0;
    logic [31:0] ins_pend = 32'h0;
    logic [3:0]  flags_pend = 4'h0;
    logic [2:0]  load_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [6:0]  bad_ops [4] = '{7'h7F, 7'h00, 7'b0001111, 7'b1110011};

    function automatic exp_t at(state_t s);
        exp_t e;
        e = '0;
        e.st = s;
        return e;
    endfunction

    function automatic exp_t dp(exp_t ein, logic [1:0] sa, logic [1:0] sb, logic [3:0] alu);
        exp_t e;
        e = ein;
        e.dp = 1'b1; e.sa = sa; e.sb = sb; e.alu = alu;
        return e;
    endfunction

    function automatic exp_t im(exp_t ein, logic [2:0] imm);
        exp_t e;
        e = ein;
        e.ci = 1'b1; e.imm = imm;
        return e;
    endfunction

    // Flags the datapath ALU would raise for rs1 - rs2.
    function automatic logic [3:0] sub_flags(logic [31:0] a, logic [31:0] b);
        logic [31:0] d;
        d = a - b;
        return {d[31], d == 32'h0, a >= b, (a[31] != b[31]) && (d[31] != a[31])};
    endfunction

    function automatic logic br_expect(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            default: return a >= b;
        endcase
    endfunction

    function automatic logic [3:0] alu_expect(logic is_r, logic [2:0] f3, logic b5);
        case (f3)
            3'd0:    return (is_r && b5) ? 4'd1 : 4'd0;
            3'd1:    return 4'd5;
            3'd2:    return 4'd4;
            3'd3:    return 4'd6;
            3'd4:    return 4'd7;
            3'd5:    return b5 ? 4'd9 : 4'd8;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic step(input exp_t e, input logic rdy, input logic rst_v);
        @(posedge clk);
        #1;
        rst_n = rst_v;
        mem_ready = rdy;
        instr = ins_pend;
        {flag_n, flag_z, flag_c, flag_v} = flags_pend;
        exp_q.push_back(e);
        mon_en = 1'b1;
    endtask

    task automatic do_reset();
        step(at(S_IDLE), 1'b0, 1'b0);
        step(at(S_IDLE), 1'b0, 1'b1);
    endtask

    task automatic trap_tail(input logic ill, input logic berr);
        exp_t e;
        e = at(S_TRAP);
        e.ill = ill;
        e.berr = berr;
        repeat (2) step(e, 1'($urandom_range(0, 1)), 1'b1);
        do_reset();
    endtask

    // Memory wait phase: returns 1 if the access times out (T waits without ready).
    task automatic mem_phase(input exp_t e, input exp_t eh, input int waits, output bit to);
        if (waits >= T) begin
            repeat (T) step(e, 1'b0, 1'b1);
            to = 1'b1;
        end else begin
            repeat (waits) step(e, 1'b0, 1'b1);
            step(eh, 1'b1, 1'b1);
            to = 1'b0;
        end
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic [31:0] a, input logic [31:0] b);
        exp_t       e, eh;
        bit         to;
        logic [6:0] op;
        logic [2:0] f3;
        logic       tk;
        op = ins[6:0];
        f3 = ins[14:12];
        ins_pend = ins;
        flags_pend = sub_flags(a, b);
        e = dp(at(S_FETCH), 2'd0, 2'd2, 4'd0);
        e.req = 1'b1;
        eh = e;
        eh.irw = 1'b1;
        eh.pcw = 1'b1;
        mem_phase(e, eh, fw, to);
        if (to) begin trap_tail(1'b0, 1'b1); return; end
        step(im(dp(at(S_DECODE), 2'd2, 2'd1, 4'd0), (op == OP_JAL) ? 3'd4 : 3'd2),
             1'($urandom_range(0, 1)), 1'b1);
        case (op)
            OP_LOAD, OP_STORE: begin
                step(im(dp(at(S_MEMADR), 2'd1, 2'd1, 4'd0), (op == OP_STORE) ? 3'd1 : 3'd0),
                     1'($urandom_range(0, 1)), 1'b1);
                if (op == OP_LOAD) begin
                    e = at(S_MEMRD); e.req = 1'b1; e.adr = 1'b1;
                    mem_phase(e, e, mw, to);
                    if (to) begin trap_tail(1'b0, 1'b1); return; end
                    e = at(S_MEMWB); e.rw = 1'b1; e.rs = 2'd1; e.ld = f3;
                    step(e, 1'($urandom_range(0, 1)), 1'b1);
                end else begin
                    e = at(S_MEMWR); e.req = 1'b1; e.we = 1'b1; e.adr = 1'b1; e.stc = f3[1:0];
                    mem_phase(e, e, mw, to);
                    if (to) begin trap_tail(1'b0, 1'b1); return; end
                end
            end
            OP_R, OP_I, OP_LUI, OP_AUIPC: begin
                if (op == OP_R)
                    e = dp(at(S_EXEC_R), 2'd1, 2'd0, alu_expect(1'b1, f3, ins[30]));
                else if (op == OP_I)
                    e = im(dp(at(S_EXEC_I), 2'd1, 2'd1, alu_expect(1'b0, f3, ins[30])), 3'd0);
                else if (op == OP_LUI)
                    e = im(dp(at(S_LUI), 2'd3, 2'd1, 4'd0), 3'd3);
                else
                    e = im(dp(at(S_AUIPC), 2'd2, 2'd1, 4'd0), 3'd3);
                step(e, 1'($urandom_range(0, 1)), 1'b1);
                e = at(S_ALUWB); e.rw = 1'b1;
                step(e, 1'($urandom_range(0, 1)), 1'b1);
            end
            OP_BRANCH: begin
                e = im(dp(at(S_BRANCH), 2'd1, 2'd0, 4'd1), 3'd2);
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    step(e, 1'($urandom_range(0, 1)), 1'b1);
                    trap_tail(1'b1, 1'b0);
                end else begin
                    tk = br_expect(f3, a, b);
                    e.pcw = tk; e.pcs = tk;
                    step(e, 1'($urandom_range(0, 1)), 1'b1);
                end
            end
            OP_JAL, OP_JALR: begin
                if (op == OP_JAL) e = im(dp(at(S_JAL), 2'd2, 2'd1, 4'd0), 3'd4);
                else              e = im(dp(at(S_JALR), 2'd1, 2'd1, 4'd0), 3'd0);
                e.pcw = 1'b1; e.pcs = 1'b1; e.rw = 1'b1; e.rs = 2'd2;
                step(e, 1'($urandom_range(0, 1)), 1'b1);
            end
            default: trap_tail(1'b1, 1'b0);
        endcase
    endtask

    always @(negedge clk) begin : monitor
        exp_t o, e;
        if (mon_en) begin
            cyc_no++;
            o = '0;
            o.st = state_o; o.req = mem_req; o.we = mem_we; o.adr = adr_src;
            o.irw = ir_write; o.pcw = pc_write; o.pcs = pc_src; o.rw = reg_write;
            o.rs = result_src; o.ld = load_ctrl; o.stc = store_ctrl;
            o.ill = illegal_inst; o.berr = bus_error;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty cycle=%0d got_state=%0d", cyc_no, state_o);
            end else begin
                e = exp_q.pop_front();
                if (e.dp) begin
                    o.dp = 1'b1; o.sa = alu_src_a; o.sb = alu_src_b; o.alu = alu_ctrl;
                end
                if (e.ci) begin
                    o.ci = 1'b1; o.imm = imm_src;
                end
                if (o !== e) begin
                    bad++;
                    $display("FAIL outputs cycle=%0d got=%h want=%h got_state=%0d want_state=%0d",
                             cyc_no, o, e, o.st, e.st);
                end
            end
        end
    end

    initial begin : stimulus
        exp_t e;
        rst_n = 1'b0;
        instr = 32'h0;
        {flag_n, flag_z, flag_c, flag_v} = 4'h0;
        mem_ready = 1'b0;
        do_reset();

        run_instr(32'h00500093, 0, 0, 32'd0, 32'd0);   // addi x1,x0,5
        run_instr(32'h00000063, 0, 0, 32'd7, 32'd7);   // beq, equal -> taken
        run_instr(32'h00001063, 0, 0, 32'd7, 32'd7);   // bne, equal -> not taken
        run_instr(32'h00002083, 0, 3, 32'd0, 32'd0);   // lw, 3 wait cycles
        run_instr(32'h00002083, 0, T - 1, 32'd0, 32'd0); // ready on last allowed cycle
        run_instr(32'h00500093, T, 0, 32'd0, 32'd0);   // fetch timeout
        run_instr(32'h0000007F, 0, 0, 32'd0, 32'd0);   // illegal opcode

        // Store stalled in MEMWR, reset asserted mid-cycle.
        ins_pend = 32'h00002023;
        e = dp(at(S_FETCH), 2'd0, 2'd2, 4'd0);
        e.req = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        step(e, 1'b1, 1'b1);
        step(im(dp(at(S_DECODE), 2'd2, 2'd1, 4'd0), 3'd2), 1'b0, 1'b1);
        step(im(dp(at(S_MEMADR), 2'd1, 2'd1, 4'd0), 3'd1), 1'b0, 1'b1);
        e = at(S_MEMWR); e.req = 1'b1; e.we = 1'b1; e.adr = 1'b1; e.stc = 2'd2;
        repeat (2) step(e, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        exp_q.push_back(at(S_IDLE));
        chk("req_before_reset", {31'h0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("req_async_drop", {31'h0, mem_req}, 32'd0);
        chk("state_async_idle", {28'h0, state_o}, {28'h0, S_IDLE});
        step(at(S_IDLE), 1'b0, 1'b1);
        run_instr(32'h00500093, 0, 0, 32'd0, 32'd0);   // refetch after release

        for (int k = 0; k < 200; k++) begin
            logic [31:0] ins, a, b;
            logic [6:0]  op;
            logic [2:0]  f3;
            logic        b5;
            int          cls, r, fw, mw;
            ins = $urandom();
            f3 = ins[14:12];
            b5 = ins[30];
            cls = $urandom_range(0, 11);
            case (cls)
                0: begin op = OP_LOAD; f3 = load_f3[$urandom_range(0, 4)]; end
                1: begin op = OP_STORE; f3 = 3'($urandom_range(0, 2)); end
                2, 3: begin op = OP_R; if (f3 != 3'd0 && f3 != 3'd5) b5 = 1'b0; end
                4, 5: begin op = OP_I; if (f3 == 3'd1) b5 = 1'b0; end
                6, 7: op = OP_BRANCH;
                8: op = OP_JAL;
                9: begin op = OP_JALR; f3 = 3'd0; end
                10: op = ($urandom_range(0, 1) == 0) ? OP_LUI : OP_AUIPC;
                default: op = bad_ops[$urandom_range(0, 3)];
            endcase
            ins[6:0] = op;
            ins[14:12] = f3;
            ins[30] = b5;
            r = $urandom_range(0, 19);
            fw = (r == 19) ? T : r % 4;
            r = $urandom_range(0, 9);
            mw = (r >= 8) ? T + r - 8 : r % 4;
            a = $urandom();
            b = ($urandom_range(0, 2) == 0) ? a : $urandom();
            run_instr(ins, fw, mw, a, b);
        end

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("scoreboard_drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
